lcv_div_iter: RTL
=================

# lcv_div_iter

Iterative radix-2 restoring divider: the inverse counterpart to the multiply-accumulate blocks. It takes a WIDTH-bit numerator and denominator over a valid/ready handshake, computes quotient and remainder one bit per cycle, and returns them over a second valid/ready handshake. It sits beside the MAC units in the execute datapath and handles division and modulo operations that the DSP slices cannot perform. Results follow truncating (round-toward-zero) semantics, signed or unsigned per request.

## Interface
Parameters:
- WIDTH, 32, operand and result width; must be ≥ 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_numer  in  WIDTH  dividend.
- in_denom  in  WIDTH  divisor.
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_quot  out  WIDTH  quotient.
- out_rem  out  WIDTH  remainder.
- out_div_zero  out  1  the request had in_denom == 0.

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- IDLE: in_ready = 1. When in_valid is high, the block accepts the request:
  - Latch the magnitudes of numer and denom. A magnitude is the absolute value if in_signed, otherwise the raw bits.
  - Latch neg_q = signed & (numer[MSB] ^ denom[MSB]), neg_r = signed & numer[MSB], and the zero and overflow flags.
  - Clear the partial remainder (WIDTH+1 bits); load the counter with WIDTH−1.
  - Go to RUN.
- RUN: in_ready = 0. Each cycle:
  - Form trial = {rem[WIDTH−1:0], q[MSB]} − {1'b0, dmag}.
  - If trial is non-negative, rem = trial and shift 1 into q; else rem = the shifted value and shift 0 into q.
  - After the step with counter = 0, go to FIXUP; otherwise decrement the counter.
- FIXUP: one cycle.
  - Apply signs: negate q if neg_q; negate rem if neg_r.
  - Overrides, in priority order:
    - Divide by zero: quot = all ones, rem = original numerator, out_div_zero = 1.
    - Signed overflow (numer = most-negative value, denom = −1): quot = most-negative value, rem = 0.
  - Go to DONE.
- DONE: out_valid = 1, outputs held stable. On out_ready, go to IDLE.
- in_ready is high only in IDLE. A new request is never accepted in the same cycle as the out handshake.
- Width rules:
  - Magnitude of the most-negative value is 2^(WIDTH−1), held as an unsigned WIDTH-bit value; no extra bit is needed.
  - The subtractor is WIDTH+1 bits wide.
  - Negation is modulo 2^WIDTH.
- Divide by zero and overflow still traverse RUN. Latency is data-independent.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_quot = 0, out_rem = 0, out_div_zero = 0, all internal registers 0.
- Latency: request accepted at edge T; out_valid rises after edge T+WIDTH+1, i.e. WIDTH cycles in RUN plus 1 in FIXUP.
- Throughput: at most one result per WIDTH+3 cycles with out_ready held high.
- Backpressure: while out_ready is low in DONE, out_* stay constant indefinitely.
- in_ready is combinational from state only; it never depends on in_valid.
- Reset asserted in any state: immediate return to IDLE with reset values. The in-flight request is dropped and no out_valid is produced for it.
- Inputs are sampled only at the accepting edge; later changes to in_* have no effect.

## Structure
- lcv_div_pkg holds:
  - the state enum (IDLE, RUN, FIXUP, DONE);
  - a helper function for magnitude/negate;
  - the counter width, $clog2(WIDTH).
- lcv_div_step is a sub-module: one combinational restoring step (WIDTH+1 subtract, select, shift), parameterised on WIDTH. Keeping it separate lets it be reused for a future unrolled radix-4 variant.
- lcv_div_iter holds the FSM, counter, sign latches, and the fixup logic.

## Test plan
WIDTH = 32 throughout.
- Unsigned: numer 100, denom 7 → quot 14, rem 2, out_valid exactly 33 cycles after accept; numer 0xFFFFFFFF, denom 1 → quot 0xFFFFFFFF, rem 0.
- Signed: −7 / 2 → quot −3 (0xFFFFFFFD), rem −1; 7 / −2 → quot −3, rem 1; −8 / −2 → quot 4, rem 0.
- Divide by zero: signed, numer 5, denom 0 → quot 0xFFFFFFFF, rem 5, out_div_zero = 1; same latency as a normal request.
- Overflow: signed, 0x80000000 / 0xFFFFFFFF → quot 0x80000000, rem 0, out_div_zero = 0. Unsigned, same operands → quot 0, rem 0x80000000.
- Backpressure: hold out_ready low for 10 cycles in DONE → outputs stable and in_ready = 0; on release, one handshake, then in_ready = 1 the next cycle.
- Reset mid-RUN: assert rst at cycle 12 of RUN → in_ready = 1 and out_valid = 0 immediately. The next request (100 / 7) returns 14 / 2 with no stale result emitted.

Source files
------------

// File: rtl/lcv_div_pkg.sv
// lcv_div_pkg: shared FSM states, counter sizing and conditional negate for the iterative divider
package lcv_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
  localparam int MAX_W = 64;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/lcv_div_step.sv
// lcv_div_step: one restoring step (WIDTH+1 trial subtract, select, shift); rem/q/dmag in, rem_n/q_n out
module lcv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] q_n
);
  logic [WIDTH:0] sh, trial;
  assign sh    = {rem, q[WIDTH-1]};
  assign trial = sh - {1'b0, dmag};
  assign rem_n = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_n   = {q[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/lcv_div_iter.sv
// lcv_div_iter: iterative radix-2 divider (2<=WIDTH<=64); in_valid/in_ready/in_numer/in_denom/in_signed request, out_valid/out_ready/out_quot/out_rem/out_div_zero result
module lcv_div_iter
  import lcv_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_numer,
  input  logic [WIDTH-1:0] in_denom,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div_zero
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] min_val = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, rem_n, q, q_n, dmag, numer, nmag, dmag_in, qs, rs;
  logic neg_q, neg_r, dz, ovf;
  lcv_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem), .q(q), .dmag(dmag), .rem_n(rem_n), .q_n(q_n)
  );
  assign nmag    = WIDTH'(cond_neg(MAX_W'(in_numer), in_signed & in_numer[WIDTH-1]));
  assign dmag_in = WIDTH'(cond_neg(MAX_W'(in_denom), in_signed & in_denom[WIDTH-1]));
  assign qs      = WIDTH'(cond_neg(MAX_W'(q), neg_q));
  assign rs      = WIDTH'(cond_neg(MAX_W'(rem), neg_r));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    state_n   = state == IDLE  ? (in_valid ? RUN : IDLE) :
                state == RUN   ? (cnt == '0 ? FIXUP : RUN) :
                state == FIXUP ? DONE :
                                 (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      rem          <= '0;
      q            <= '0;
      dmag         <= '0;
      numer        <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz           <= 1'b0;
      ovf          <= 1'b0;
      out_quot     <= '0;
      out_rem      <= '0;
      out_div_zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      q     <= nmag;
      dmag  <= dmag_in;
      numer <= in_numer;
      neg_q <= in_signed & (in_numer[WIDTH-1] ^ in_denom[WIDTH-1]);
      neg_r <= in_signed & in_numer[WIDTH-1];
      dz    <= in_denom == '0;
      ovf   <= in_signed && in_numer == min_val && in_denom == '1;
      rem   <= '0;
      cnt   <= CW'(WIDTH - 1);
    end else if (state == RUN) begin
      rem <= rem_n;
      q   <= q_n;
      cnt <= cnt - CW'(1);
    end else if (state == FIXUP) begin
      out_quot     <= dz ? '1 : ovf ? min_val : qs;
      out_rem      <= dz ? numer : ovf ? '0 : rs;
      out_div_zero <= dz;
    end
  end
endmodule
